// File: rtl/cache_lru_table_pkg.sv
// cache_lru_table_pkg: constants, entry layout and helpers shared with the 2-way replacement selector
package cache_lru_table_pkg;
  localparam int IDX_W = 8;
  localparam int SETS = 1 << IDX_W;
  localparam logic [1:0] WAY0 = 2'b01;
  localparam logic [1:0] WAY1 = 2'b10;
  localparam logic LRU_W0_VICTIM = 1'b1;
  typedef enum logic {IDLE, FLUSH} state_t;
  typedef struct packed {
    logic [1:0] valid;
    logic       lru;
  } entry_t;
  function automatic logic way_ok(input logic [1:0] way);
    return way == WAY0 || way == WAY1;
  endfunction
  // The way just used becomes MRU, so the other way is the victim.
  function automatic logic lru_of(input logic [1:0] way);
    return way == WAY1 ? LRU_W0_VICTIM : ~LRU_W0_VICTIM;
  endfunction
endpackage

// File: rtl/cache_flush_seq.sv
// cache_flush_seq: invalidate-all sweep sequencer driving one array entry per cycle
module cache_flush_seq
  import cache_lru_table_pkg::*;
(
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_flush_req,
  output logic             o_busy,
  output logic             o_flush_done,
  output logic             o_sweep_we,
  output logic [IDX_W-1:0] o_sweep_idx
);
  state_t           r_state, w_state_nx;
  logic [IDX_W-1:0] r_ctr, w_ctr_nx;
  logic             r_done, w_done_nx, w_last;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= FLUSH;
      r_ctr   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_ctr   <= w_ctr_nx;
      r_done  <= w_done_nx;
    end
  end
  always_comb begin
    w_last     = r_ctr == IDX_W'(SETS - 1);
    w_state_nx = r_state == FLUSH ? (w_last ? IDLE : FLUSH) : (i_flush_req ? FLUSH : IDLE);
    w_ctr_nx   = r_state == FLUSH ? r_ctr + 1'b1 : '0;
    w_done_nx  = r_state == FLUSH && w_last;
  end
  assign o_busy       = r_state == FLUSH;
  assign o_flush_done = r_done;
  assign o_sweep_we   = o_busy;
  assign o_sweep_idx  = r_ctr;
endmodule

// File: rtl/cache_lru_table.sv
// cache_lru_table: per-set valid/LRU store for a 2-way cache with write-first lookup and flush sweep
module cache_lru_table
  import cache_lru_table_pkg::*;
(
  input  logic             i_clock,
  input  logic             i_reset,
  input  logic             i_rd_en,
  input  logic [IDX_W-1:0] i_rd_idx,
  output logic [1:0]       o_valid_way,
  output logic             o_lru_out,
  input  logic             i_touch_en,
  input  logic [IDX_W-1:0] i_touch_idx,
  input  logic [1:0]       i_touch_way,
  input  logic             i_fill_en,
  input  logic [IDX_W-1:0] i_fill_idx,
  input  logic [1:0]       i_fill_way,
  input  logic             i_inv_en,
  input  logic [IDX_W-1:0] i_inv_idx,
  input  logic [1:0]       i_inv_way,
  input  logic             i_flush_req,
  output logic             o_busy,
  output logic             o_flush_done
);
  entry_t           r_mem [SETS];
  entry_t           w_rd, w_touch, w_fill, w_inv;
  logic             w_sweep_we;
  logic [IDX_W-1:0] w_sweep_idx;
  cache_flush_seq u_seq (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_flush_req  (i_flush_req),
    .o_busy       (o_busy),
    .o_flush_done (o_flush_done),
    .o_sweep_we   (w_sweep_we),
    .o_sweep_idx  (w_sweep_idx)
  );
  // Combined effect of this cycle's touch/fill/inv on set k; fill beats inv on the same way.
  function automatic entry_t upd(input logic [IDX_W-1:0] k);
    logic f, t, c;
    f = i_fill_en && way_ok(i_fill_way) && i_fill_idx == k;
    t = i_touch_en && way_ok(i_touch_way) && i_touch_idx == k;
    c = i_inv_en && way_ok(i_inv_way) && i_inv_idx == k;
    upd.valid = (r_mem[k].valid & ~(c ? i_inv_way : 2'b00)) | (f ? i_fill_way : 2'b00);
    upd.lru   = f ? lru_of(i_fill_way) : t ? lru_of(i_touch_way) : r_mem[k].lru;
  endfunction
  always_comb begin
    w_rd    = upd(i_rd_idx);
    w_touch = upd(i_touch_idx);
    w_fill  = upd(i_fill_idx);
    w_inv   = upd(i_inv_idx);
  end
  always_ff @(posedge i_clock) begin
    if (w_sweep_we) begin
      r_mem[w_sweep_idx] <= '0;
    end else if (!i_reset) begin
      r_mem[i_touch_idx] <= w_touch;
      r_mem[i_inv_idx]   <= w_inv;
      r_mem[i_fill_idx]  <= w_fill;
    end
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) {o_valid_way, o_lru_out} <= '0;
    else if (i_rd_en) {o_valid_way, o_lru_out} <= o_busy ? '0 : w_rd;
  end
  always_ff @(posedge i_clock) begin
    if (!i_reset && !o_busy)
      assert ((!i_touch_en || way_ok(i_touch_way)) && (!i_fill_en || way_ok(i_fill_way)) &&
              (!i_inv_en || way_ok(i_inv_way)))
      else $error("cache_lru_table: non one-hot way on an enabled request");
  end
endmodule

// File: tb/tb_cache_lru_table.sv
// tb_cache_lru_table: directed vectors with hand-computed expectations for cache_lru_table
module tb_cache_lru_table;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rd_en = 0, touch_en = 0, fill_en = 0, inv_en = 0, flush_req = 0;
  logic [7:0] rd_idx = 0, touch_idx = 0, fill_idx = 0, inv_idx = 0;
  logic [1:0] touch_way = 0, fill_way = 0, inv_way = 0;
  logic [1:0] valid_way;
  logic       lru_out, busy, flush_done;
  int         total = 0, bad = 0;
  always #5 clk = ~clk;
  cache_lru_table dut (
    .i_clock(clk), .i_reset(reset),
    .i_rd_en(rd_en), .i_rd_idx(rd_idx), .o_valid_way(valid_way), .o_lru_out(lru_out),
    .i_touch_en(touch_en), .i_touch_idx(touch_idx), .i_touch_way(touch_way),
    .i_fill_en(fill_en), .i_fill_idx(fill_idx), .i_fill_way(fill_way),
    .i_inv_en(inv_en), .i_inv_idx(inv_idx), .i_inv_way(inv_way),
    .i_flush_req(flush_req), .o_busy(busy), .o_flush_done(flush_done)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
    {rd_en, touch_en, fill_en, inv_en, flush_req} = '0;
  endtask
  task automatic rd_chk(input string tag, input logic [7:0] idx, input logic [1:0] v, input logic l);
    rd_en = 1; rd_idx = idx;
    step;
    check({tag, "_v"}, valid_way, v);
    check({tag, "_l"}, lru_out, l);
  endtask
  task automatic fill(input logic [7:0] idx, input logic [1:0] way);
    fill_en = 1; fill_idx = idx; fill_way = way;
  endtask
  task automatic sweep_check(input string tag);
    int n = 0, p = 0;
    while (busy && n < 400) begin
      step;
      n++;
      p += int'(flush_done);
    end
    check({tag, "_len"}, n, 256);
    check({tag, "_done"}, flush_done, 1);
    check({tag, "_pulses"}, p, 1);
    step;
    check({tag, "_done_clr"}, flush_done, 0);
  endtask
  initial begin
    step;
    reset = 0;
    check("rst_busy", busy, 1);
    check("rst_v", valid_way, 0);
    check("rst_l", lru_out, 0);
    check("rst_done", flush_done, 0);
    sweep_check("init");
    rd_chk("rd5", 5, 2'b00, 0);
    fill(3, 2'b01); step;
    rd_chk("f3a", 3, 2'b01, 0);
    fill(3, 2'b10); step;
    rd_chk("f3b", 3, 2'b11, 1);
    touch_en = 1; touch_idx = 3; touch_way = 2'b01; step;
    rd_chk("t3", 3, 2'b11, 0);
    fill(7, 2'b10);
    rd_chk("fwd7", 7, 2'b10, 1);
    fill(9, 2'b10); step;
    fill(9, 2'b01); inv_en = 1; inv_idx = 9; inv_way = 2'b01;
    rd_chk("fi9", 9, 2'b11, 0);
    touch_en = 1; touch_idx = 9; touch_way = 2'b10;
    rd_chk("t9", 9, 2'b11, 1);
    inv_en = 1; inv_idx = 9; inv_way = 2'b01;
    rd_chk("inv9", 9, 2'b10, 1);
    step;
    check("hold_v", valid_way, 2'b10);
    check("hold_l", lru_out, 1);
    fill(20, 2'b01); inv_en = 1; inv_idx = 9; inv_way = 2'b10; step;
    rd_chk("ind20", 20, 2'b01, 0);
    rd_chk("ind9", 9, 2'b00, 1);
    touch_en = 1; touch_idx = 20; touch_way = 2'b01; fill(20, 2'b10);
    rd_chk("tf20", 20, 2'b11, 1);
    fill(0, 2'b01); step;
    fill(255, 2'b10); step;
    rd_chk("pre255", 255, 2'b10, 1);
    flush_req = 1; step;
    check("fl_busy", busy, 1);
    begin
      int n = 0, p = 0;
      while (busy && n < 400) begin
        if (n == 10) begin fill(5, 2'b01); flush_req = 1; end
        if (n == 20) begin rd_en = 1; rd_idx = 255; end
        step;
        n++;
        p += int'(flush_done);
        if (n == 21) begin
          check("busy_rd_v", valid_way, 0);
          check("busy_rd_l", lru_out, 0);
        end
      end
      check("fl_len", n, 256);
      check("fl_pulses", p, 1);
      check("fl_done", flush_done, 1);
    end
    rd_chk("post0", 0, 2'b00, 0);
    rd_chk("post255", 255, 2'b00, 0);
    rd_chk("post10", 10, 2'b00, 0);
    rd_chk("post5", 5, 2'b00, 0);
    fill(3, 2'b01);
    rd_chk("pre6", 3, 2'b01, 0);
    flush_req = 1; step;
    begin
      int p = 0;
      for (int i = 0; i < 100; i++) begin
        step;
        p += int'(flush_done);
      end
      check("mid_pulses", p, 0);
      check("mid_busy", busy, 1);
    end
    reset = 1; step;
    reset = 0;
    check("rr_busy", busy, 1);
    check("rr_v", valid_way, 0);
    sweep_check("rr");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
